// File: rtl/sipo.sv
// -----------------------------------------------------------------------------
// sipo -- serial-in / parallel-out beat packer
//
// Packs narrow DATA_IN_WIDTH beats into one DATA_OUT_WIDTH word. The first
// beat of a word lands in the least-significant slot. A word is emitted when
// all NUM_SLOTS slots are filled or when a beat arrives with IN_LAST set. In
// that case the unfilled upper slots are zero and OUT_KEEP marks which slots
// hold received data.
//
// Handshake (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both 1. A valid word holds OUT_DAT/OUT_KEEP/OUT_LAST
// stable until it is taken. IN_RDY never looks at IN_VLD, IN_LAST or IN_DAT.
// It does follow OUT_RDY combinationally, so that a full output register can
// be drained and refilled in the same cycle.
//
// Ports
//   CLK       in   clock, all state updates on the rising edge
//   RST       in   synchronous active-high reset
//   IN_VLD    in   input beat valid
//   IN_LAST   in   input beat ends a packet
//   IN_DAT    in   input beat data [DATA_IN_WIDTH]
//   IN_RDY    out  input beat accepted this cycle when IN_VLD is 1
//   OUT_DAT   out  packed word [DATA_OUT_WIDTH]
//   OUT_KEEP  out  per-slot "holds received data" flags [NUM_SLOTS]
//   OUT_VLD   out  packed word valid
//   OUT_LAST  out  packed word ends a packet
//   OUT_RDY   in   downstream accepts the word
// -----------------------------------------------------------------------------
module sipo #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 64
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      IN_VLD,
    input  logic                                      IN_LAST,
    input  logic [DATA_IN_WIDTH-1:0]                  IN_DAT,
    output logic                                      IN_RDY,
    output logic [DATA_OUT_WIDTH-1:0]                 OUT_DAT,
    output logic [DATA_OUT_WIDTH/DATA_IN_WIDTH-1:0]   OUT_KEEP,
    output logic                                      OUT_VLD,
    output logic                                      OUT_LAST,
    input  logic                                      OUT_RDY
);

    // DATA_OUT_WIDTH must be an integer multiple of DATA_IN_WIDTH, giving at
    // least two slots.
    localparam int NUM_SLOTS = DATA_OUT_WIDTH / DATA_IN_WIDTH;
    localparam int CNT_W     = $clog2(NUM_SLOTS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_SLOTS - 1);

    logic [DATA_OUT_WIDTH-1:0] acc;        // slots already filled for the current word
    logic [CNT_W-1:0]          cnt;        // slot the next accepted beat goes to
    logic [DATA_OUT_WIDTH-1:0] merged;     // acc with the current beat dropped into slot cnt
    logic [NUM_SLOTS-1:0]      keep_next;  // slots [cnt:0] set
    logic                      in_fire;
    logic                      out_fire;
    logic                      final_beat;

    assign IN_RDY     = !RST && (!OUT_VLD || OUT_RDY);
    assign in_fire    = IN_VLD && IN_RDY;
    assign out_fire   = OUT_VLD && OUT_RDY;
    assign final_beat = (cnt == LAST_SLOT) || IN_LAST;

    // Slots above cnt in acc are always zero, so replacing slot cnt with the
    // beat gives the word with unfilled slots already cleared.
    always_comb begin
        merged    = acc;
        keep_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (cnt == CNT_W'(i)) begin
                merged[i*DATA_IN_WIDTH +: DATA_IN_WIDTH] = IN_DAT;
            end
            keep_next[i] = (CNT_W'(i) <= cnt);
        end
    end

    // Pack side: accumulator and slot counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_fire) begin
            if (final_beat) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= merged;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output register. A final beat can only be accepted when the register is
    // empty or being drained this cycle, so loading it takes priority over
    // clearing it: the new word simply replaces the departing one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_DAT  <= '0;
            OUT_KEEP <= '0;
            OUT_LAST <= 1'b0;
            OUT_VLD  <= 1'b0;
        end else if (in_fire && final_beat) begin
            OUT_DAT  <= merged;
            OUT_KEEP <= keep_next;
            OUT_LAST <= IN_LAST;
            OUT_VLD  <= 1'b1;
        end else if (out_fire) begin
            OUT_DAT  <= '0;
            OUT_KEEP <= '0;
            OUT_LAST <= 1'b0;
            OUT_VLD  <= 1'b0;
        end
    end

endmodule
